accel_stall_ctrl: RTL and testbench

Sequencer and stall source for the long-latency accelerators (NTT, PWAM, multiplier, Keccak) that share the core's issue slot. It launches one accelerator at a time, holds the pipeline-register stall lines until the selected unit reports completion, and aborts with a sticky error on timeout. It sits beside decode and drives the per-unit stall inputs of every 64-bit pipeline register.

---
 rtl/accel_stall_ctrl_if.sv | 36 +++
 rtl/accel_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_accel_stall_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_stall_ctrl_if.sv
// accel_stall_ctrl_if
//   Bundles the issue/done/stall signals between decode, the long-latency
//   accelerators and the stall controller. CLK and RST stay plain ports.
//   master : decode/accelerator side (drives issue, dstall, done, limit, clear)
//   slave  : accel_stall_ctrl side (drives start pulses, stalls, busy, error)
interface accel_stall_ctrl_if #(
    parameter int CNT_BITS = 16
);
    logic                issue_valid;
    logic [1:0]          issue_sel;      // 0 NTT, 1 PWAM, 2 MUL, 3 KECCAK
    logic                dstall;
    logic [3:0]          acc_done;       // indexed like issue_sel
    logic [CNT_BITS-1:0] timeout_limit;  // 0 disables the timeout
    logic                err_clr;

    logic [3:0]          acc_start;
    logic                ntt_stall;
    logic                pwam_stall;
    logic                mulstall;
    logic                keccak_stall;
    logic                stall_out;
    logic                busy;
    logic                timeout_err;

    modport master (
        output issue_valid, issue_sel, dstall, acc_done, timeout_limit, err_clr,
        input  acc_start, ntt_stall, pwam_stall, mulstall, keccak_stall,
               stall_out, busy, timeout_err
    );

    modport slave (
        input  issue_valid, issue_sel, dstall, acc_done, timeout_limit, err_clr,
        output acc_start, ntt_stall, pwam_stall, mulstall, keccak_stall,
               stall_out, busy, timeout_err
    );
endinterface

// File: rtl/accel_stall_ctrl.sv
// accel_stall_ctrl
//   Launches one long-latency accelerator at a time and holds that unit's
//   pipeline-register stall line until it reports done, or aborts with a
//   sticky timeout error after timeout_limit WAIT cycles.
// Ports:
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset; forces every output to 0 while high
//   bus  : accel_stall_ctrl_if.slave (issue/done/limit/clear in,
//          start pulses/unit stalls/stall_out/busy/timeout_err out)
// CNT_BITS must match the CNT_BITS of the connected interface.
module accel_stall_ctrl #(
    parameter int CNT_BITS = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    accel_stall_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          sel_q;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_inc;
    logic [3:0]          acc_start_q;
    logic                busy_q;
    logic                timeout_err_q;
    logic                done_sel;
    logic                timeout_hit;
    logic [3:0]          unit_stall;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_BITS'(1);

    assign done_sel = bus.acc_done[sel_q];

    // Done takes priority over a timeout reached in the same WAIT cycle.
    assign timeout_hit = (state == WAIT) && !done_sel &&
                         (bus.timeout_limit != '0) && (cnt == bus.timeout_limit);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            sel_q         <= 2'd0;
            cnt           <= '0;
            acc_start_q   <= 4'b0000;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            acc_start_q <= 4'b0000;

            // Setting the sticky error beats a simultaneous clear.
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                timeout_err_q <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    // With dstall high the issue waits here; the unit stall
                    // keeps the instruction parked in decode meanwhile.
                    if (bus.issue_valid && !bus.dstall) begin
                        sel_q       <= bus.issue_sel;
                        cnt         <= '0;
                        acc_start_q <= 4'b0001 << bus.issue_sel;
                        busy_q      <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    // Counting from START makes the counter read 1 in the
                    // first WAIT cycle.
                    cnt   <= cnt_inc;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (done_sel || timeout_hit) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: unit_stall gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        unit_stall = 4'b0000;
        if (!RST) begin
            unique case (state)
                IDLE:        if (bus.issue_valid) unit_stall = 4'b0001 << bus.issue_sel;
                START, WAIT: unit_stall = 4'b0001 << sel_q;
                default:     unit_stall = 4'b0000;
            endcase
        end
    end

    assign bus.ntt_stall    = unit_stall[0];
    assign bus.pwam_stall   = unit_stall[1];
    assign bus.mulstall     = unit_stall[2];
    assign bus.keccak_stall = unit_stall[3];

    // Registered outputs are also gated so that nothing leaks during the
    // reset cycle itself (e.g. reset asserted while in START).
    assign bus.stall_out   = !RST && (bus.dstall || (|unit_stall));
    assign bus.acc_start   = RST ? 4'b0000 : acc_start_q;
    assign bus.busy        = busy_q && !RST;
    assign bus.timeout_err = timeout_err_q && !RST;

endmodule

// File: tb/tb_accel_stall_ctrl.sv
// tb_accel_stall_ctrl
//   Directed bench for accel_stall_ctrl. Start pulses are scoreboarded: each
//   accepted issue pushes the expected one-hot pulse and its cycle, and a
//   negedge monitor pops and compares whenever acc_start is non-zero.
module tb_accel_stall_ctrl;

    localparam int CNT_BITS = 16;

    typedef struct {
        logic [3:0] start;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    accel_stall_ctrl_if #(.CNT_BITS(CNT_BITS)) bus ();

    accel_stall_ctrl #(.CNT_BITS(CNT_BITS)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Start-pulse scoreboard plus the one-stall-at-a-time invariant.
    always @(negedge clk) begin
        exp_t e;
        if (bus.acc_start !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_start", {28'b0, bus.acc_start}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("start_pulse", {28'b0, bus.acc_start}, {28'b0, e.start});
                check("start_cycle", cyc, e.cyc);
            end
        end
        if (!rst) begin
            check("stall_onehot",
                  int'($countones({bus.ntt_stall, bus.pwam_stall, bus.mulstall, bus.keccak_stall}) <= 1),
                  32'd1);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_sel   = 2'd0;
        bus.dstall      = 1'b0;
        bus.acc_done    = 4'b0000;
        bus.err_clr     = 1'b0;
    endtask

    // Drive an issue that the DUT accepts this cycle; its pulse comes next cycle.
    task automatic launch(input logic [1:0] sel);
        exp_t e;
        bus.issue_valid = 1'b1;
        bus.issue_sel   = sel;
        e.start = 4'b0001 << sel;
        e.cyc   = cyc + 1;
        sb_q.push_back(e);
    endtask

    initial begin
        // ---------------- Reset ----------------
        bus.issue_valid   = 1'b1;
        bus.issue_sel     = 2'd2;
        bus.dstall        = 1'b1;
        bus.acc_done      = 4'b0000;
        bus.timeout_limit = '0;
        bus.err_clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample();
        check("rst_mulstall", bus.mulstall, 0);
        check("rst_stall_out", bus.stall_out, 0);
        check("rst_acc_start", bus.acc_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        next();
        rst = 1'b0;
        sample();
        check("post_rst_mulstall", bus.mulstall, 1);
        check("post_rst_stall_out", bus.stall_out, 1);
        check("post_rst_busy", bus.busy, 0);
        next();
        idle_inputs();

        // ---------------- NTT launch, done at cycle 5 ----------------
        next();
        launch(2'd0);
        sample();
        check("ntt_c0_stall", bus.ntt_stall, 1);
        check("ntt_c0_busy", bus.busy, 0);
        for (int k = 1; k <= 6; k++) begin
            next();
            bus.acc_done = (k == 5) ? 4'b0001 : 4'b0000;
            sample();
            check("ntt_stall", bus.ntt_stall, (k <= 5) ? 1 : 0);
            check("ntt_busy", bus.busy, 1);
        end
        next();
        idle_inputs();
        sample();
        check("ntt_c7_busy", bus.busy, 0);
        check("ntt_c7_stall", bus.ntt_stall, 0);

        // ---------------- Keccak, wrong-unit done ignored ----------------
        next();
        launch(2'd3);
        next();
        bus.acc_done = 4'b1000;              // ignored in START
        next();
        bus.acc_done = 4'b0100;              // other unit, ignored in WAIT
        sample();
        check("kec_wait_stall", bus.keccak_stall, 1);
        check("kec_mulstall", bus.mulstall, 0);
        next();
        bus.acc_done = 4'b0000;
        sample();
        check("kec_still_stalled", bus.keccak_stall, 1);
        next();
        bus.acc_done = 4'b1000;
        sample();
        check("kec_done_cycle_stall", bus.keccak_stall, 1);
        next();
        idle_inputs();
        sample();
        check("kec_drain_stall", bus.keccak_stall, 0);
        check("kec_drain_busy", bus.busy, 1);
        next();
        sample();
        check("kec_idle_busy", bus.busy, 0);

        // ---------------- Timeout, limit 3 ----------------
        bus.timeout_limit = CNT_BITS'(3);
        next();
        launch(2'd1);                        // cycle 0, START at 1
        repeat (4) next();                   // cycle 4: WAIT with cnt == 3
        sample();
        check("to_c4_stall", bus.pwam_stall, 1);
        check("to_c4_err", bus.timeout_err, 0);
        next();
        bus.issue_valid = 1'b0;
        sample();
        check("to_c5_err", bus.timeout_err, 1);
        check("to_c5_stall", bus.pwam_stall, 0);
        check("to_c5_busy", bus.busy, 1);
        next();
        sample();
        check("to_c6_busy", bus.busy, 0);
        check("to_c6_err", bus.timeout_err, 1);

        // Second timeout with err_clr in the same cycle: set wins.
        launch(2'd1);
        repeat (4) next();
        bus.err_clr = 1'b1;
        next();
        bus.err_clr     = 1'b0;
        bus.issue_valid = 1'b0;
        sample();
        check("to_set_wins", bus.timeout_err, 1);
        next();
        bus.err_clr = 1'b1;
        next();
        bus.err_clr = 1'b0;
        sample();
        check("to_cleared", bus.timeout_err, 0);
        bus.timeout_limit = '0;

        // ---------------- Launch held off by dstall ----------------
        next();
        bus.issue_valid = 1'b1;
        bus.issue_sel   = 2'd1;
        bus.dstall      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("ds_pwam_stall", bus.pwam_stall, 1);
            check("ds_busy", bus.busy, 0);
            check("ds_stall_out", bus.stall_out, 1);
            next();
        end
        bus.dstall = 1'b0;
        launch(2'd1);                        // accepted now
        next();
        bus.dstall = 1'b1;                   // no effect outside IDLE
        sample();
        check("ds_start_busy", bus.busy, 1);
        next();
        bus.acc_done = 4'b0010;              // done in first WAIT cycle
        sample();
        check("ds_wait_stall", bus.pwam_stall, 1);
        next();
        bus.acc_done    = 4'b0000;
        bus.issue_valid = 1'b0;
        sample();
        check("ds_drain_stall", bus.pwam_stall, 0);
        check("ds_drain_stall_out", bus.stall_out, 1);
        next();
        bus.dstall = 1'b0;
        sample();
        check("ds_idle_busy", bus.busy, 0);
        check("ds_idle_stall_out", bus.stall_out, 0);

        // ---------------- Reset mid-WAIT ----------------
        next();
        launch(2'd2);
        next();                              // START
        next();                              // WAIT
        bus.issue_valid = 1'b0;
        next();                              // WAIT, reset asserted now
        rst = 1'b1;
        sample();
        check("rw_rst_mulstall", bus.mulstall, 0);
        check("rw_rst_busy", bus.busy, 0);
        next();
        rst = 1'b0;
        bus.acc_done = 4'b0100;              // late done in IDLE
        sample();
        check("rw_idle_busy", bus.busy, 0);
        check("rw_idle_mulstall", bus.mulstall, 0);
        next();
        bus.acc_done = 4'b0000;
        sample();
        check("rw_still_idle", bus.busy, 0);

        // ---------------- Done and timeout tie, limit 2 ----------------
        bus.timeout_limit = CNT_BITS'(2);
        next();
        launch(2'd0);
        next();                              // START
        next();                              // WAIT cnt 1
        next();                              // WAIT cnt 2 == limit
        bus.acc_done = 4'b0001;
        sample();
        check("tie_stall", bus.ntt_stall, 1);
        next();
        idle_inputs();
        sample();
        check("tie_drain_stall", bus.ntt_stall, 0);
        check("tie_drain_busy", bus.busy, 1);
        check("tie_no_err", bus.timeout_err, 0);
        next();
        sample();
        check("tie_idle_busy", bus.busy, 0);
        check("tie_idle_err", bus.timeout_err, 0);

        next();
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
